// File: rtl/sc_regctrl_pkg.sv
// Shared definitions for the register/counter sequencing controller and its
// timing helpers: FSM state encodings and default datapath widths.
package sc_regctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } regCtrlState_t;

  localparam int REGCTRL_DATAWIDTH_DEFAULT  = 4;
  localparam int REGCTRL_PRESCWIDTH_DEFAULT = 20;

endpackage

// File: rtl/sc_regctrl_prescaler.sv
// Free-running prescaler: counts enabled cycles and flags terminal count when
// the count equals the programmed period, wrapping to zero on the next enable.
module sc_regctrl_prescaler
  import sc_regctrl_pkg::*;
#(
  parameter int RegPRESC_WIDTH = REGCTRL_PRESCWIDTH_DEFAULT
) (
  input  logic                      SC_RegPRESC_CLOCK_50,
  input  logic                      SC_RegPRESC_RESET_InLow,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [RegPRESC_WIDTH-1:0] period,
  output logic                      tc
);

  logic [RegPRESC_WIDTH-1:0] count;

  assign tc = (count == period);

  // Clear wins over enable so a fresh sequence always starts from zero.
  always_ff @(posedge SC_RegPRESC_CLOCK_50 or negedge SC_RegPRESC_RESET_InLow) begin
    if (!SC_RegPRESC_RESET_InLow) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sc_regcounter_ctrl.sv
// Sequencing controller: clears a downstream register counter, then issues a
// programmed number of increment strobes at a prescaled tick rate and reports done.
module sc_regcounter_ctrl
  import sc_regctrl_pkg::*;
#(
  parameter int RegCTRL_DATAWIDTH  = REGCTRL_DATAWIDTH_DEFAULT,
  parameter int RegCTRL_PRESCWIDTH = REGCTRL_PRESCWIDTH_DEFAULT
) (
  input  logic                          SC_RegCTRL_CLOCK_50,
  input  logic                          SC_RegCTRL_RESET_InLow,
  input  logic                          SC_RegCTRL_start_InHigh,
  input  logic                          SC_RegCTRL_pause_InHigh,
  input  logic                          SC_RegCTRL_abort_InHigh,
  input  logic [RegCTRL_PRESCWIDTH-1:0] SC_RegCTRL_period_InBUS,
  input  logic [RegCTRL_DATAWIDTH-1:0]  SC_RegCTRL_limit_InBUS,
  output logic                          SC_RegCTRL_clear_OutHigh,
  output logic                          SC_RegCTRL_inc_OutHigh,
  output logic                          SC_RegCTRL_busy_OutHigh,
  output logic                          SC_RegCTRL_done_OutHigh,
  output logic [1:0]                    SC_RegCTRL_state_OutBUS
);

  regCtrlState_t state, nextState;

  logic [RegCTRL_PRESCWIDTH-1:0] periodReg;
  logic [RegCTRL_DATAWIDTH-1:0]  limitReg;
  logic [RegCTRL_DATAWIDTH-1:0]  tickCount;
  logic [RegCTRL_DATAWIDTH-1:0]  lastTick;
  logic                          startAccept;
  logic                          runActive;
  logic                          prescTc;
  logic                          incFire;

  assign startAccept = (state == IDLE) && SC_RegCTRL_start_InHigh && !SC_RegCTRL_abort_InHigh;
  assign runActive   = (state == RUN) && !SC_RegCTRL_pause_InHigh && !SC_RegCTRL_abort_InHigh;
  assign incFire     = runActive && prescTc;
  assign lastTick    = limitReg - RegCTRL_DATAWIDTH'(1);

  assign SC_RegCTRL_state_OutBUS = state;

  sc_regctrl_prescaler #(
    .RegPRESC_WIDTH(RegCTRL_PRESCWIDTH)
  ) prescaler (
    .SC_RegPRESC_CLOCK_50   (SC_RegCTRL_CLOCK_50),
    .SC_RegPRESC_RESET_InLow(SC_RegCTRL_RESET_InLow),
    .enable                 (runActive),
    .clear                  (state == CLEAR),
    .period                 (periodReg),
    .tc                     (prescTc)
  );

  always_ff @(posedge SC_RegCTRL_CLOCK_50 or negedge SC_RegCTRL_RESET_InLow) begin
    if (!SC_RegCTRL_RESET_InLow) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Period and limit are captured only on an accepted start, so start while busy cannot disturb them.
  always_ff @(posedge SC_RegCTRL_CLOCK_50 or negedge SC_RegCTRL_RESET_InLow) begin
    if (!SC_RegCTRL_RESET_InLow) begin
      periodReg <= '0;
      limitReg  <= '0;
      tickCount <= '0;
    end else begin
      if (startAccept) begin
        periodReg <= SC_RegCTRL_period_InBUS;
        limitReg  <= SC_RegCTRL_limit_InBUS;
      end
      if (state == CLEAR) begin
        tickCount <= '0;
      end else if (incFire) begin
        tickCount <= tickCount + 1'b1;
      end
    end
  end

  always_comb begin
    nextState                = state;
    SC_RegCTRL_clear_OutHigh = 1'b0;
    SC_RegCTRL_inc_OutHigh   = 1'b0;
    SC_RegCTRL_busy_OutHigh  = 1'b0;
    SC_RegCTRL_done_OutHigh  = 1'b0;
    case (state)
      IDLE: begin
        if (startAccept) nextState = CLEAR;
      end
      CLEAR: begin
        SC_RegCTRL_clear_OutHigh = 1'b1;
        SC_RegCTRL_busy_OutHigh  = 1'b1;
        if (SC_RegCTRL_abort_InHigh) nextState = IDLE;
        else if (limitReg == '0)     nextState = DONE;
        else                         nextState = RUN;
      end
      RUN: begin
        SC_RegCTRL_busy_OutHigh = 1'b1;
        if (SC_RegCTRL_abort_InHigh) begin
          SC_RegCTRL_clear_OutHigh = 1'b1;
          nextState                = IDLE;
        end else if (incFire) begin
          SC_RegCTRL_inc_OutHigh = 1'b1;
          if (tickCount == lastTick) nextState = DONE;
        end
      end
      DONE: begin
        SC_RegCTRL_done_OutHigh = 1'b1;
        nextState               = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule
